// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: denomination count, FSM encoding
// and the common mask/table types.
package change_dispenser_pkg;

    localparam int NUM_COINS         = 3;
    localparam int DEFAULT_INV_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SELECT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_DONE     = 2'd3
    } state_e;

    typedef logic [NUM_COINS-1:0]         coin_mask_t;
    typedef logic [NUM_COINS-1:0][31:0]   value_table_t;

endpackage

// File: rtl/change_dispenser_coin_selector.sv
// Combinational greedy pick: the highest-valued denomination that still fits the
// remaining amount and has coins in stock. Also usable for return-value estimates.
module coin_selector
    import change_dispenser_pkg::*;
(
    input  logic [NUM_COINS-1:0][31:0] value_table,
    input  logic [NUM_COINS-1:0]       avail,
    input  logic [31:0]                remaining,
    output logic                       found,
    output logic [NUM_COINS-1:0]       pick
);

    // Ascending scan, so the last qualifying index (the largest value) wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (avail[i] && (value_table[i] != 32'd0) && (value_table[i] <= remaining)) begin
                found   = 1'b1;
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change payout engine: pays an amount one coin per hopper handshake, largest
// denomination first, tracking a per-denomination coin inventory.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int INV_WIDTH   = DEFAULT_INV_WIDTH,
    parameter int INIT_COUNT  = 4,
    parameter int HOP_TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_COINS-1:0][31:0] coin_value_table,
    input  logic                       req_valid,
    input  logic [31:0]                req_amount,
    output logic                       req_ready,
    input  logic [NUM_COINS-1:0]       coin_deposit,
    output logic                       dispense_valid,
    output logic [NUM_COINS-1:0]       dispense_coin,
    input  logic                       dispense_ready,
    output logic                       done,
    output logic [31:0]                shortfall,
    output logic                       fault,
    output logic [NUM_COINS-1:0]       inv_empty
);

    localparam int STALL_W = $clog2(HOP_TIMEOUT + 1);

    state_e                 state_q;
    logic [31:0]            remaining_q;
    logic [31:0]            shortfall_q;
    logic                   fault_q;
    logic                   done_q;
    logic                   valid_q;
    coin_mask_t             coin_q;
    logic [STALL_W-1:0]     stall_q;
    logic [INV_WIDTH-1:0]   inv_q [NUM_COINS];
    logic [INV_WIDTH-1:0]   inv_d [NUM_COINS];

    coin_mask_t             avail;
    coin_mask_t             take;
    coin_mask_t             pick;
    logic                   found;
    logic [31:0]            selValue;

    coin_selector u_selector (
        .value_table (coin_value_table),
        .avail       (avail),
        .remaining   (remaining_q),
        .found       (found),
        .pick        (pick)
    );

    always_comb begin
        selValue = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            avail[i] = (inv_q[i] != '0);
            if (coin_q[i]) begin
                selValue = selValue | coin_value_table[i];
            end
        end
        take = (state_q == S_DISPENSE && dispense_ready) ? coin_q : '0;
    end

    // A deposit and a take on the same denomination cancel; increments saturate.
    always_comb begin
        for (int i = 0; i < NUM_COINS; i++) begin
            inv_d[i] = inv_q[i];
            if (coin_deposit[i] && !take[i] && (inv_q[i] != '1)) begin
                inv_d[i] = inv_q[i] + 1'b1;
            end else if (take[i] && !coin_deposit[i]) begin
                inv_d[i] = inv_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_COINS; i++) begin
            if (!reset_n) begin
                inv_q[i] <= INV_WIDTH'(INIT_COUNT);
            end else begin
                inv_q[i] <= inv_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            shortfall_q <= '0;
            fault_q     <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            coin_q      <= '0;
            stall_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        remaining_q <= req_amount;
                        shortfall_q <= '0;
                        fault_q     <= 1'b0;
                        state_q     <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if ((remaining_q == 32'd0) || !found) begin
                        shortfall_q <= remaining_q;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        coin_q  <= pick;
                        valid_q <= 1'b1;
                        stall_q <= '0;
                        state_q <= S_DISPENSE;
                    end
                end
                S_DISPENSE: begin
                    if (dispense_ready) begin
                        remaining_q <= remaining_q - selValue;
                        valid_q     <= 1'b0;
                        coin_q      <= '0;
                        stall_q     <= '0;
                        state_q     <= S_SELECT;
                    end else if (stall_q == STALL_W'(HOP_TIMEOUT - 1)) begin
                        // Hopper stuck: the coin still on offer was never taken.
                        fault_q     <= 1'b1;
                        valid_q     <= 1'b0;
                        coin_q      <= '0;
                        stall_q     <= '0;
                        shortfall_q <= remaining_q;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign dispense_valid = valid_q;
    assign dispense_coin  = coin_q;
    assign done           = done_q;
    assign shortfall      = shortfall_q;
    assign fault          = fault_q;
    assign inv_empty      = ~avail;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy payout model queues the expected
// coin sequence per request and each hopper handshake pops and compares it.
module tb_change_dispenser;
    import change_dispenser_pkg::*;

    localparam int HOP     = 15;
    localparam int INV_MAX = 255;

    logic                       clk;
    logic                       reset_n;
    logic [NUM_COINS-1:0][31:0] coin_value_table;
    logic                       req_valid;
    logic [31:0]                req_amount;
    logic                       req_ready;
    logic [NUM_COINS-1:0]       coin_deposit;
    logic                       dispense_valid;
    logic [NUM_COINS-1:0]       dispense_coin;
    logic                       dispense_ready;
    logic                       done;
    logic [31:0]                shortfall;
    logic                       fault;
    logic [NUM_COINS-1:0]       inv_empty;

    int checkCount = 0;
    int errorCount = 0;
    int tbl[NUM_COINS] = '{100, 500, 1000};
    int invModel[NUM_COINS];

    change_dispenser #(.INV_WIDTH(8), .INIT_COUNT(4), .HOP_TIMEOUT(HOP)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .coin_value_table (coin_value_table),
        .req_valid        (req_valid),
        .req_amount       (req_amount),
        .req_ready        (req_ready),
        .coin_deposit     (coin_deposit),
        .dispense_valid   (dispense_valid),
        .dispense_coin    (dispense_coin),
        .dispense_ready   (dispense_ready),
        .done             (done),
        .shortfall        (shortfall),
        .fault            (fault),
        .inv_empty        (inv_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int greedy(input int rem);
        int p = -1;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (tbl[i] != 0 && tbl[i] <= rem && invModel[i] != 0) p = i;
        end
        return p;
    endfunction

    function automatic logic [31:0] modelEmpty();
        logic [31:0] m = '0;
        for (int i = 0; i < NUM_COINS; i++) m[i] = (invModel[i] == 0);
        return m;
    endfunction

    task automatic applyReset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < NUM_COINS; i++) invModel[i] = 4;
    endtask

    task automatic depositCoins(input logic [NUM_COINS-1:0] mask, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            coin_deposit = mask;
            for (int i = 0; i < NUM_COINS; i++) begin
                if (mask[i] && invModel[i] < INV_MAX) invModel[i]++;
            end
        end
        @(negedge clk);
        coin_deposit = '0;
    endtask

    // One payout; depositIdx >= 0 deposits that denomination on its first take.
    task automatic applyStimulus(input int amount, input bit stall, input int depositIdx);
        int expQ[$];
        int rem = amount;
        int p;
        int e;
        int nCoins;
        int coinNum = 0;
        int expShort;
        bit expFault;
        bit gotDone = 1'b0;
        bit depDone = 1'b0;
        if (!stall) begin
            p = greedy(rem);
            while (p >= 0) begin
                expQ.push_back(p);
                invModel[p]--;
                rem -= tbl[p];
                p = greedy(rem);
            end
            if (depositIdx >= 0) invModel[depositIdx]++;
            expShort = rem;
            expFault = 1'b0;
        end else begin
            expQ.push_back(greedy(amount));
            expShort = amount;
            expFault = 1'b1;
        end
        nCoins = expQ.size();
        @(negedge clk);
        req_valid      = 1'b1;
        req_amount     = amount;
        dispense_ready = !stall;
        @(negedge clk);
        req_valid  = 1'b0;
        req_amount = 32'hDEAD;
        checkOutput("acceptedBusy", req_ready, 0);
        for (int k = 1; k < 700 && !gotDone; k++) begin
            if (k > 1) @(negedge clk);
            coin_deposit = '0;
            if (dispense_valid) begin
                if (stall) begin
                    checkOutput("offeredCoin", dispense_coin, 1 << expQ[0]);
                end else if (expQ.size() == 0) begin
                    checkOutput("extraCoin", dispense_coin, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("coin", dispense_coin, 1 << e);
                    checkOutput("coinCycle", k, 2 + 2 * coinNum);
                    coinNum++;
                    if (depositIdx == e && !depDone) begin
                        coin_deposit = NUM_COINS'(1 << e);
                        depDone = 1'b1;
                    end
                end
            end
            if (done) begin
                gotDone = 1'b1;
                checkOutput("doneCycle", k, stall ? HOP + 2 : 2 * nCoins + 2);
                checkOutput("shortfall", shortfall, expShort);
                checkOutput("fault", fault, expFault);
            end
        end
        checkOutput("doneSeen", gotDone, 1);
        @(negedge clk);
        coin_deposit   = '0;
        dispense_ready = 1'b1;
        checkOutput("donePulse", done, 0);
        checkOutput("readyAfter", req_ready, 1);
        checkOutput("shortfallHeld", shortfall, expShort);
        checkOutput("faultHeld", fault, expFault);
        checkOutput("invEmpty", inv_empty, modelEmpty());
    endtask

    initial begin
        coin_value_table[0] = 32'd100;
        coin_value_table[1] = 32'd500;
        coin_value_table[2] = 32'd1000;
        reset_n        = 1'b0;
        req_valid      = 1'b0;
        req_amount     = '0;
        coin_deposit   = '0;
        dispense_ready = 1'b1;
        repeat (2) @(negedge clk);
        applyReset();

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("idleReady", req_ready, 1);
            checkOutput("idleValid", dispense_valid, 0);
            checkOutput("idleEmpty", inv_empty, 0);
            checkOutput("idleDone", done, 0);
        end

        applyStimulus(1600, 1'b0, -1);
        applyStimulus(0, 1'b0, -1);

        applyReset();
        applyStimulus(4000, 1'b0, -1);
        applyStimulus(1000, 1'b0, -1);
        applyStimulus(500, 1'b1, -1);
        applyStimulus(500, 1'b0, 1);
        applyStimulus(1200, 1'b0, -1);

        applyReset();
        applyStimulus(4800, 1'b0, -1);
        applyStimulus(2000, 1'b0, -1);
        checkOutput("allEmpty", inv_empty, 3'b111);

        depositCoins(3'b010, 1);
        depositCoins(3'b001, 260);
        applyStimulus(30000, 1'b0, -1);

        // Reset in the middle of a payout must abandon it silently.
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = 32'd1600;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < NUM_COINS; i++) invModel[i] = 4;
        checkOutput("rstReady", req_ready, 1);
        checkOutput("rstValid", dispense_valid, 0);
        checkOutput("rstEmpty", inv_empty, modelEmpty());
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("rstNoDone", done, 0);
        end
        applyStimulus(1600, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
